// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the cipher datapaths.
//   WORD_W         : width of one key-schedule word
//   state_t        : key-schedule controller states (IDLE, EXPAND, DONE)
//   sbox_fwd()     : forward AES S-box lookup
//   xtime()        : multiply by x in GF(2^8), used to advance Rcon
//   nk_of/nr_of/nw_of : key words, rounds and schedule words from the key width
package aes_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1 (0x80 -> 0x1b).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nk_of(input int key_length);
        return key_length / 32;
    endfunction

    function automatic int nr_of(input int key_length);
        return nk_of(key_length) + 6;
    endfunction

    function automatic int nw_of(input int key_length);
        return 4 * (nr_of(key_length) + 1);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//   data : input byte
//   sub  : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    assign sub = sbox_fwd(data);

endmodule

// File: rtl/dec_key_schedule.sv
// Iterative AES key expansion (one 32-bit word per clock) presenting all round
// keys in parallel, ordered for the decryption pipeline.
//   clk, rst       : clock, synchronous active-high reset
//   key_in         : cipher key, word 0 in the most significant 32 bits
//   key_load       : start expansion; accepted when key_ready is high
//   key_ready      : high in IDLE and DONE
//   keys_valid     : high while round_keys_dec holds a complete schedule
//   round_keys_dec : slot j (bits [128*j +: 128]) = encryption round key NR-j
module dec_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_LENGTH = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [KEY_LENGTH-1:0]       key_in,
    input  logic                        key_load,
    output logic                        key_ready,
    output logic                        keys_valid,
    output logic [128*(nr_of(KEY_LENGTH)+1)-1:0] round_keys_dec
);

    localparam int NK = nk_of(KEY_LENGTH);
    localparam int NR = nr_of(KEY_LENGTH);
    localparam int NW = nw_of(KEY_LENGTH);

    localparam logic [5:0] NK_W    = 6'(NK);
    localparam logic [5:0] NK_MASK = 6'(NK - 1);
    localparam logic [5:0] LAST_W  = 6'(NW - 1);

    if (KEY_LENGTH != 128 && KEY_LENGTH != 256) begin : g_bad_key_length
        $error("dec_key_schedule: KEY_LENGTH must be 128 or 256");
    end

    state_t              state;
    state_t              state_nxt;
    logic                load_acc;
    logic [WORD_W-1:0]   w [NW];
    logic [5:0]          cnt;
    logic [7:0]          rcon;

    logic [WORD_W-1:0]   w_prev;
    logic [WORD_W-1:0]   w_far;
    logic [WORD_W-1:0]   sub_in;
    logic [WORD_W-1:0]   sub_out;
    logic [WORD_W-1:0]   temp;
    logic                rcon_step;
    logic                sub_only;

    // Controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_acc  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (key_load) begin
                    load_acc  = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (cnt == LAST_W) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign key_ready  = (state != EXPAND);
    assign keys_valid = (state == DONE);

    // Next-word generation; only meaningful while EXPAND (NK <= cnt <= NW-1).
    assign w_prev    = w[cnt - 6'd1];
    assign w_far     = w[cnt - NK_W];
    assign rcon_step = ((cnt & NK_MASK) == 6'd0);
    assign sub_only  = (NK == 8) && (cnt[2:0] == 3'd4);
    assign sub_in    = rcon_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data (sub_in[8*b +: 8]),
            .sub  (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = w_prev;
        if (rcon_step) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (sub_only) begin
            temp = sub_out;
        end
    end

    // Schedule storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NW; k++) begin
                w[k] <= '0;
            end
            cnt  <= 6'd0;
            rcon <= 8'h01;
        end else if (load_acc) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key_in[KEY_LENGTH-1-32*k -: 32];
            end
            cnt  <= NK_W;
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            w[cnt] <= w_far ^ temp;
            cnt    <= cnt + 6'd1;
            if (rcon_step) begin
                rcon <= xtime(rcon);
            end
        end
    end

    // Decryption ordering: slot j carries encryption round key NR-j.
    for (genvar j = 0; j <= NR; j++) begin : g_slot
        localparam int R = NR - j;
        assign round_keys_dec[128*j +: 128] = {w[4*R], w[4*R+1], w[4*R+2], w[4*R+3]};
    end

endmodule

// File: tb/tb_dec_key_schedule.sv
module tb_dec_key_schedule;

    logic              clk = 1'b0;
    logic              rst;
    logic [127:0]      key128;
    logic              load128;
    logic              ready128;
    logic              valid128;
    logic [128*11-1:0] rk128;
    logic [255:0]      key256;
    logic              load256;
    logic              ready256;
    logic              valid256;
    logic [128*15-1:0] rk256;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dec_key_schedule #(.KEY_LENGTH(128)) u_dut128 (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key128),
        .key_load       (load128),
        .key_ready      (ready128),
        .keys_valid     (valid128),
        .round_keys_dec (rk128)
    );

    dec_key_schedule #(.KEY_LENGTH(256)) u_dut256 (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key256),
        .key_load       (load256),
        .key_ready      (ready256),
        .keys_valid     (valid256),
        .round_keys_dec (rk256)
    );

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] slot0;
        logic [127:0] slot9;
    } vec_t;

    vec_t vecs [2];

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] LAST_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] LAST_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a key for one edge on the 128-bit instance.
    task automatic load_128(input logic [127:0] k);
        key128  = k;
        load128 = 1'b1;
        tick();
        load128 = 1'b0;
    endtask

    // Count edges until valid; bounded so a stuck design still reaches the summary.
    task automatic wait_valid_128(input int already, output int n, output bit ready_low);
        n = already;
        ready_low = 1'b1;
        while (!valid128 && n < 200) begin
            if (ready128) ready_low = 1'b0;
            tick();
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  rl;
        int  pulses;

        vecs[0] = '{name: "A1", key: KEY_A1, slot0: LAST_A1,
                    slot9: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{name: "C1", key: KEY_C1, slot0: LAST_C1,
                    slot9: 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};

        rst = 1'b1; key128 = '0; load128 = 1'b0; key256 = '0; load256 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", {127'b0, valid128}, 128'd0);
        check("rst_ready", {127'b0, ready128}, 128'd1);
        check("rst_rk_zero", {127'b0, (rk128 == '0)}, 128'd1);
        check("rst256_ready", {127'b0, ready256}, 128'd1);

        // Table-driven AES-128 vectors (each load from DONE/IDLE).
        for (int v = 0; v < 2; v++) begin
            load_128(vecs[v].key);
            check({vecs[v].name, "_ready_low"}, {127'b0, ready128}, 128'd0);
            check({vecs[v].name, "_valid_low"}, {127'b0, valid128}, 128'd0);
            wait_valid_128(0, n, rl);
            check({vecs[v].name, "_latency"}, 128'(n), 128'd40);
            check({vecs[v].name, "_busy_ready"}, {127'b0, rl}, 128'd1);
            check({vecs[v].name, "_slot0"}, rk128[0 +: 128], vecs[v].slot0);
            check({vecs[v].name, "_slot9"}, rk128[128*9 +: 128], vecs[v].slot9);
            check({vecs[v].name, "_slot10"}, rk128[128*10 +: 128], vecs[v].key);
            check({vecs[v].name, "_ready_done"}, {127'b0, ready128}, 128'd1);
        end

        // Reload in DONE (currently holding C1) with A1.
        load_128(KEY_A1);
        check("reload_valid_fall", {127'b0, valid128}, 128'd0);
        wait_valid_128(0, n, rl);
        check("reload_latency", 128'(n), 128'd40);
        check("reload_slot0", rk128[0 +: 128], LAST_A1);

        // Load while busy: second request ignored.
        load_128(KEY_C1);
        repeat (9) begin
            if (ready128) rl = 1'b0;
            tick();
        end
        key128  = KEY_A1;
        load128 = 1'b1;
        tick();
        load128 = 1'b0;
        wait_valid_128(10, n, rl);
        check("busy_latency", 128'(n), 128'd40);
        check("busy_ready_low", {127'b0, rl}, 128'd1);
        check("busy_slot0", rk128[0 +: 128], LAST_C1);

        // Reset mid-expansion.
        load_128(KEY_C1);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {127'b0, valid128}, 128'd0);
        check("midrst_ready", {127'b0, ready128}, 128'd1);
        check("midrst_rk_zero", {127'b0, (rk128 == '0)}, 128'd1);
        load_128(KEY_A1);
        wait_valid_128(0, n, rl);
        check("midrst_latency", 128'(n), 128'd40);
        check("midrst_slot0", rk128[0 +: 128], LAST_A1);

        // key_load held high: one valid cycle per expansion, restart in first DONE cycle.
        key128  = KEY_C1;
        load128 = 1'b1;
        pulses  = 0;
        for (int c = 0; c < 90; c++) begin
            tick();
            if (valid128) begin
                pulses++;
                if (pulses == 1) check("held_slot0", rk128[0 +: 128], LAST_C1);
            end
        end
        check("held_pulses", 128'(pulses), 128'd2);
        load128 = 1'b0;
        repeat (45) tick();

        // AES-256 C.3.
        key256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        load256 = 1'b1;
        tick();
        load256 = 1'b0;
        check("aes256_ready_low", {127'b0, ready256}, 128'd0);
        n = 0;
        while (!valid256 && n < 200) begin
            tick();
            n++;
        end
        check("aes256_latency", 128'(n), 128'd52);
        check("aes256_slot0", rk256[0 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("aes256_slot14", rk256[128*14 +: 128], 128'h000102030405060708090a0b0c0d0e0f);
        check("aes256_slot13", rk256[128*13 +: 128], 128'h101112131415161718191a1b1c1d1e1f);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
